// File: rtl/partial_sum_accumulator_if.sv
// Stream bundle for the partial sum accumulator: partial-sum input side and
// held-result output side. The slave modport is the accumulator's view.
interface partial_sum_accumulator_if #(
  parameter int DATAW = 16,
  parameter int ACCW  = 32,
  parameter int CNTW  = 9
);
  logic [DATAW-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             sign_unsign_ni;
  logic [CNTW-1:0]  len_i;
  logic [ACCW-1:0]  data_o;
  logic             valid_o;
  logic             ready_i;
  logic             overflow_o;

  modport master (
    output data_i, valid_i, sign_unsign_ni, len_i, ready_i,
    input  ready_o, data_o, valid_o, overflow_o
  );

  modport slave (
    input  data_i, valid_i, sign_unsign_ni, len_i, ready_i,
    output ready_o, data_o, valid_o, overflow_o
  );
endinterface

// File: rtl/partial_sum_accumulator.sv
// Partial sum accumulator: sums a programmed number of consecutive tree-root
// beats into a wide wrapping accumulator and holds the result until consumed.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no result in progress; next accepted beat starts one
//   S_ACC  | result in progress, waiting for remaining beats
//   S_HOLD | result presented on valid_o; a beat accepted while it is
//          | consumed becomes the first beat of the next result
module partial_sum_accumulator #(
  parameter int DATAW  = 16,
  parameter int ACCW   = 32,
  parameter int MAXLEN = 256,
  localparam int CNTW  = $clog2(MAXLEN + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  partial_sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   len_q, len_d;
  logic              mode_q, mode_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  logic [DATAW-1:0]  din;
  logic              ready;
  logic              beat;
  logic [CNTW-1:0]   len_eff;
  logic [ACCW-1:0]   ext_first;
  logic [ACCW-1:0]   ext_acc;
  logic [ACCW-1:0]   sum;
  logic              carry;
  logic              beat_ovf;

  assign din     = bus.data_i;
  // ready depends only on state and downstream ready, never on valid_i
  assign ready   = (state_q != S_HOLD) || bus.ready_i;
  assign beat    = bus.valid_i && ready;
  assign len_eff = (bus.len_i == '0) ? CNTW'(1) : bus.len_i;

  // first beat extends with the live mode bit, later beats with the latched one
  assign ext_first = bus.sign_unsign_ni ? ACCW'($signed(din)) : ACCW'(din);
  assign ext_acc   = mode_q ? ACCW'($signed(din)) : ACCW'(din);

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, ext_acc};
  assign beat_ovf = mode_q ? ((acc_q[ACCW-1] == ext_acc[ACCW-1]) &&
                              (sum[ACCW-1] != acc_q[ACCW-1]))
                           : carry;

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (beat) begin
          acc_d   = ext_first;
          cnt_d   = CNTW'(1);
          len_d   = len_eff;
          mode_d  = bus.sign_unsign_ni;
          ovf_d   = 1'b0;
          state_d = (len_eff == CNTW'(1)) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = sum;
          cnt_d = cnt_q + CNTW'(1);
          ovf_d = ovf_q | beat_ovf;
          if (cnt_q + CNTW'(1) == len_q) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.ready_i) begin
          if (beat) begin
            acc_d   = ext_first;
            cnt_d   = CNTW'(1);
            len_d   = len_eff;
            mode_d  = bus.sign_unsign_ni;
            ovf_d   = 1'b0;
            state_d = (len_eff == CNTW'(1)) ? S_HOLD : S_ACC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_HOLD);
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= CNTW'(1);
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.data_o     = acc_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = ovf_q;

endmodule
